cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Receiving end of the execution-unit CDB submit interface: collects cdb_bfm submissions from NUM_SRC
//   fixed-latency exec units (int/mul/div/mem), buffers each source in its own FIFO, and broadcasts
//   at most one result per cycle on the common data bus.
// - Gives per-source hold back to the issue logic so that fixed-latency units never overflow their buffer.
// PARAMETERS
// - NUM_SRC      4  number of submitting exec units; index 0 = lowest RR rank after reset
// - DEPTH        4  entries per source FIFO (power of 2, >=2)
// - HOLD_MARGIN  1  o_src_hold[s] asserts when free entries of FIFO s <= HOLD_MARGIN (covers in-flight ops)
// PORTS
// - clk          in   1                 clock, all state on rising edge
// - rst          in   1                 synchronous, active-high reset
// - i_flush      in   1                 discard all buffered results (mispredict recovery)
// - i_submit     in   NUM_SRC x cdb_bfm  per-source submission; entry taken when .cdb_valid=1
// - o_src_hold   out  NUM_SRC           1 = issue logic must not grant source s
// - o_cdb        out  cdb_bfm           broadcast; .cdb_valid=1 marks a result this cycle
// - o_overflow   out  1                 sticky: a valid submit was dropped on a full FIFO
// BEHAVIOUR
// - Reset: all FIFOs empty, occupancy 0, RR pointer 0, o_cdb all-zero, o_src_hold all 0, o_overflow 0.
// - Enqueue: i_submit[s].cdb_valid=1 in cycle N writes {branch,tag,result} into FIFO s at edge end of N.
// - o_cdb is combinational from the granted FIFO head; the granted head pops at the same edge.
//   Earliest latency: submit in cycle N -> o_cdb valid in cycle N+1. No same-cycle bypass.
// - Idle (all FIFOs empty): o_cdb = all-zero (valid 0, branch 0, tag 0, result 0).
// - Arbitration: round-robin over non-empty FIFOs starting at RR pointer; after a grant to s the pointer
//   becomes (s+1) mod NUM_SRC; pointer unchanged when nothing is granted. One grant per cycle max.
// - Per-source order preserved (FIFO); no ordering guarantee between sources.
// - Occupancy counter per FIFO, width $clog2(DEPTH+1); read/write pointers wrap mod DEPTH.
// - Full + pop same cycle: push accepted (occupancy stays DEPTH). Full + no pop + push: push dropped,
//   o_overflow sets next cycle and holds until rst. Empty + push: occupancy 0->1, no pop that cycle.
// - o_src_hold[s] = (DEPTH - occupancy[s]) <= HOLD_MARGIN, derived from registered occupancy.
// - i_flush=1 in cycle N: all FIFOs empty and pointers 0 after edge; submits in cycle N dropped
//   (not counted as overflow); o_cdb in cycle N still shows the current grant but nothing pops into
//   a later cycle; RR pointer unchanged.
// - rst dominates i_flush and submits; rst mid-stream discards all buffered entries.
// CONFIGURATION
// - CDB_BRANCH_PRIO_EN defined: any FIFO head with .cdb_branch=1 wins over RR (lowest index among branch
//   heads); RR pointer still advances past the granted source. Undefined: pure round-robin,
//   .cdb_branch only passed through.
// TESTING
// - Single src2 submit tag=5 result=32'h64 in cycle 0 -> o_cdb valid tag=5 result=32'h64 in cycle 1 only.
// - src0..src3 submit together tags 1..4 after reset -> o_cdb tags 1,2,3,4 in cycles 1-4, then idle.
// - DEPTH=4, HOLD_MARGIN=1: src1 submits 3 with src0 always winning -> o_src_hold[1]=1 after the 3rd write;
//   a 5th write while full and not granted -> o_overflow=1 and stays 1 until rst.
// - FIFO full and granted, new submit same cycle -> no overflow, occupancy stays 4, order preserved.
// - i_flush with 2 entries in src0 and a concurrent src3 submit -> next cycle o_cdb idle, holds 0, overflow 0.
// - CDB_BRANCH_PRIO_EN: src0 tag 7 (branch=0) and src3 tag 9 (branch=1) queued, RR ptr 0 -> tag 9 first,
//   then tag 7; without the macro -> tag 7 first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs, round-robin broadcast, issue hold.
// Optional CDB_BRANCH_PRIO_EN: branch-carrying heads win over round-robin.
package cdb_pkg;
  parameter int TAG_W  = 6;
  parameter int DATA_W = 32;

  typedef struct packed {
    logic              cdb_valid;
    logic              cdb_branch;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_result;
  } cdb_bfm;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_MARGIN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  cdb_bfm [NUM_SRC-1:0] i_submit,
  output logic   [NUM_SRC-1:0] o_src_hold,
  output cdb_bfm               o_cdb,
  output logic                 o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  cdb_bfm           mem    [NUM_SRC][DEPTH];
  logic [AW-1:0]    rd_ptr [NUM_SRC];
  logic [AW-1:0]    wr_ptr [NUM_SRC];
  logic [OW-1:0]    occ    [NUM_SRC];
  logic [SW-1:0]    rr_ptr;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] drop;
  logic             gnt_vld;
  logic [SW-1:0]    gnt_idx;
  logic [SW:0]      sum;
  logic [SW-1:0]    cand;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      nonempty[s]   = occ[s] != '0;
      full[s]       = occ[s] == OW'(DEPTH);
      o_src_hold[s] = (DEPTH - int'(occ[s])) <= HOLD_MARGIN;
    end
  end

  // Scan from the far end so the candidate closest to rr_ptr is kept.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (SW+1)'(i);
      if (sum >= (SW+1)'(NUM_SRC))
        sum = sum - (SW+1)'(NUM_SRC);
      cand = sum[SW-1:0];
      if (nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef CDB_BRANCH_PRIO_EN
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (nonempty[s] && mem[s][rd_ptr[s]].cdb_branch) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(s);
      end
    end
`endif
  end

  always_comb begin
    o_cdb = '0;
    if (gnt_vld) begin
      o_cdb           = mem[gnt_idx][rd_ptr[gnt_idx]];
      o_cdb.cdb_valid = 1'b1;
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      pop[s]  = gnt_vld && (gnt_idx == SW'(s));
      push[s] = i_submit[s].cdb_valid && !i_flush
                && (!full[s] || pop[s]);
      drop[s] = i_submit[s].cdb_valid && !i_flush
                && full[s] && !pop[s];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s])
        mem[s][wr_ptr[s]] <= i_submit[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        occ[s]    <= '0;
      end
      rr_ptr     <= '0;
      o_overflow <= 1'b0;
    end else if (i_flush) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        occ[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push[s])
          wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])
          rd_ptr[s] <= rd_ptr[s] + 1'b1;
        if (push[s] && !pop[s])
          occ[s] <= occ[s] + 1'b1;
        else if (!push[s] && pop[s])
          occ[s] <= occ[s] - 1'b1;
      end
      if (|drop)
        o_overflow <= 1'b1;
      if (gnt_vld)
        rr_ptr <= (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed submits, queued expectations.
// A negedge monitor compares every broadcast against the queue head.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_flush;
  cdb_bfm [3:0] i_submit;
  logic   [3:0] o_src_hold;
  cdb_bfm       o_cdb;
  logic         o_overflow;

  int nvec = 0;
  int nmis = 0;
  cdb_bfm exp_q[$];

  cdb_arbiter #(.NUM_SRC(4), .DEPTH(4), .HOLD_MARGIN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (i_flush),
    .i_submit   (i_submit),
    .o_src_hold (o_src_hold),
    .o_cdb      (o_cdb),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && o_cdb.cdb_valid) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL cdb_unexpected: got tag=%0d result=%h, none required",
                 o_cdb.cdb_tag, o_cdb.cdb_result);
      end else begin
        cdb_bfm e;
        e = exp_q.pop_front();
        if (o_cdb !== e) begin
          nmis++;
          $display("FAIL cdb_order: got v=%b b=%b tag=%0d res=%h, need v=%b b=%b tag=%0d res=%h",
                   o_cdb.cdb_valid, o_cdb.cdb_branch, o_cdb.cdb_tag, o_cdb.cdb_result,
                   e.cdb_valid, e.cdb_branch, e.cdb_tag, e.cdb_result);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h, need %h", nm, act, req);
    end
  endtask

  task automatic clr();
    i_submit = '0;
    i_flush  = 1'b0;
  endtask

  task automatic sub(input int s, input logic [5:0] tag,
                     input logic [31:0] res, input logic br);
    i_submit[s].cdb_valid  = 1'b1;
    i_submit[s].cdb_branch = br;
    i_submit[s].cdb_tag    = tag;
    i_submit[s].cdb_result = res;
  endtask

  task automatic expect_out(input logic [5:0] tag, input logic [31:0] res,
                            input logic br);
    cdb_bfm e;
    e.cdb_valid  = 1'b1;
    e.cdb_branch = br;
    e.cdb_tag    = tag;
    e.cdb_result = res;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 64'(o_cdb), 64'd0);
  endtask

  task automatic chk_drain(input string nm);
    chk(nm, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cdb", 64'(o_cdb), 64'd0);
    chk("rst_hold", 64'(o_src_hold), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single submit: visible only in the following cycle
    sub(2, 6'd5, 32'h64, 1'b0);
    expect_out(6'd5, 32'h64, 1'b0);
    mid();
    chk_idle("no_bypass");
    cyc();
    mid();
    chk("single_tag", 64'(o_cdb.cdb_tag), 64'd5);
    cyc();
    mid();
    chk_idle("single_after");
    chk_drain("single_drain");
    cyc();

    // four sources at once drain in index order
    do_reset();
    for (int s = 0; s < 4; s++) begin
      sub(s, 6'(s + 1), 32'(100 + s + 1), 1'b0);
      expect_out(6'(s + 1), 32'(100 + s + 1), 1'b0);
    end
    for (int c = 0; c < 6; c++) begin
      mid();
      if (c == 5) chk_idle("rr4_idle");
      cyc();
    end
    chk_drain("rr4_drain");

    // src0 and src1 flooded: src1 fills, full+pop accepts, 8th push drops
    do_reset();
    for (int c = 0; c < 7; c++) begin
      expect_out(6'h20 + 6'(c), 32'h2000 + 32'(c), 1'b0);
      expect_out(6'h10 + 6'(c), 32'h1000 + 32'(c), 1'b0);
    end
    expect_out(6'h27, 32'h2007, 1'b0);
    for (int c = 0; c < 17; c++) begin
      if (c < 8) begin
        sub(0, 6'h20 + 6'(c), 32'h2000 + 32'(c), 1'b0);
        sub(1, 6'h10 + 6'(c), 32'h1000 + 32'(c), 1'b0);
      end
      mid();
      case (c)
        3: chk("hold_c3", 64'(o_src_hold), 64'h0);
        4: chk("hold_c4", 64'(o_src_hold), 64'h2);
        5: chk("hold_c5", 64'(o_src_hold), 64'h3);
        7: chk("ovf_c7", 64'(o_overflow), 64'd0);
        8: chk("ovf_c8", 64'(o_overflow), 64'd1);
        16: begin
          chk_idle("flood_idle");
          chk("ovf_sticky", 64'(o_overflow), 64'd1);
          chk("flood_hold", 64'(o_src_hold), 64'h0);
        end
        default: ;
      endcase
      cyc();
    end
    chk_drain("flood_drain");

    // flush: current grant still shown, queues and late submit discarded
    do_reset();
    sub(0, 6'h01, 32'hA1, 1'b0);
    sub(1, 6'h02, 32'hA2, 1'b0);
    sub(2, 6'h03, 32'hA3, 1'b0);
    expect_out(6'h01, 32'hA1, 1'b0);
    expect_out(6'h02, 32'hA2, 1'b0);
    expect_out(6'h03, 32'hA3, 1'b0);
    mid();
    cyc();
    sub(0, 6'h04, 32'hA4, 1'b0);
    mid();
    cyc();
    sub(0, 6'h05, 32'hA5, 1'b0);
    mid();
    cyc();
    i_flush = 1'b1;
    sub(3, 6'h06, 32'hA6, 1'b0);
    mid();
    chk("flush_show", 64'(o_cdb.cdb_tag), 64'h03);
    cyc();
    mid();
    chk_idle("flush_idle");
    chk("flush_hold", 64'(o_src_hold), 64'h0);
    chk("flush_ovf", 64'(o_overflow), 64'd0);
    cyc();
    sub(2, 6'h07, 32'hA7, 1'b0);
    sub(3, 6'h08, 32'hA8, 1'b0);
    expect_out(6'h07, 32'hA7, 1'b0);
    expect_out(6'h08, 32'hA8, 1'b0);
    for (int c = 0; c < 4; c++) begin
      mid();
      if (c == 3) chk_idle("postflush_idle");
      cyc();
    end
    chk_drain("flush_drain");

    // branch head against round-robin
    do_reset();
    sub(0, 6'd7, 32'h77, 1'b0);
    sub(3, 6'd9, 32'h99, 1'b1);
`ifdef CDB_BRANCH_PRIO_EN
    expect_out(6'd9, 32'h99, 1'b1);
    expect_out(6'd7, 32'h77, 1'b0);
`else
    expect_out(6'd7, 32'h77, 1'b0);
    expect_out(6'd9, 32'h99, 1'b1);
`endif
    for (int c = 0; c < 4; c++) begin
      mid();
      if (c == 3) chk_idle("br_idle");
      cyc();
    end
    chk_drain("br_drain");

    // reset mid-stream discards buffered entries and a same-cycle submit
    do_reset();
    sub(0, 6'h11, 32'hB1, 1'b0);
    sub(1, 6'h12, 32'hB2, 1'b0);
    sub(2, 6'h13, 32'hB3, 1'b0);
    expect_out(6'h11, 32'hB1, 1'b0);
    mid();
    cyc();
    mid();
    cyc();
    rst = 1'b1;
    sub(0, 6'h15, 32'hB5, 1'b0);
    mid();
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk_idle("rst_mid_idle");
      cyc();
    end
    chk("rst_mid_hold", 64'(o_src_hold), 64'h0);
    chk_drain("rst_mid_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
